// File: rtl/icdf_fold_pipe_if.sv
// Beat bus of the inverse-CDF fold stage: LANES Sobol samples in, folded lanes plus flags out.
interface icdf_fold_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int TAG_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_u;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_x;
  logic [LANES-1:0]       out_negate;
  logic [LANES-1:0]       out_tail;
  logic [LANES-1:0]       out_clamped;
  logic [TAG_W-1:0]       out_tag;

  // The fold stage itself.
  modport slave (
    input  in_valid, in_u, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_negate, out_tail, out_clamped, out_tag
  );

  // Sample source and downstream consumer.
  modport master (
    output in_valid, in_u, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_negate, out_tail, out_clamped, out_tag
  );
endinterface

// File: rtl/icdf_fold_pipe.sv
// Multi-lane Sobol fold stage: clamps each sample into (0,1), folds it to (0,0.5]
// and flags negate/tail/clamp, through a two-stage valid/ready pipeline.
module icdf_fold_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int LANES = 4,
  parameter int EPS   = 1,
  parameter int P_LOW = 1589,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  icdf_fold_pipe_if.slave bus,
  output logic [31:0]     beat_count
);
  typedef logic signed [WIDTH-1:0] sword_t;
  typedef logic        [WIDTH-1:0] uword_t;

  localparam sword_t ONE  = sword_t'(64'd1 << FRAC);
  localparam sword_t HALF = sword_t'(64'd1 << (FRAC - 1));
  localparam sword_t LO   = sword_t'(EPS);
  localparam sword_t HI   = sword_t'((64'd1 << FRAC) - 64'(EPS));
  localparam uword_t TAIL = uword_t'(P_LOW);

  sword_t             in_lane [LANES];
  sword_t             clamp_u [LANES];
  logic [LANES-1:0]   clamp_flag;
  uword_t             fold_x  [LANES];
  logic [LANES-1:0]   fold_neg;
  logic [LANES-1:0]   fold_tail;

  logic               s1_valid_q, s1_valid_d;
  sword_t             s1_u_q [LANES];
  sword_t             s1_u_d [LANES];
  logic [LANES-1:0]   s1_clamped_q, s1_clamped_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

  logic               s2_valid_q, s2_valid_d;
  uword_t             s2_x_q [LANES];
  uword_t             s2_x_d [LANES];
  logic [LANES-1:0]   s2_negate_q, s2_negate_d;
  logic [LANES-1:0]   s2_tail_q, s2_tail_d;
  logic [LANES-1:0]   s2_clamped_q, s2_clamped_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic [31:0]        beat_count_q, beat_count_d;
  logic               s1_load;
  logic               s2_load;
  logic               in_fire;

  // S2 frees up when it is empty or its beat is taken; S1 follows S2, so bubbles collapse.
  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;
  assign in_fire      = bus.in_valid && s1_load;

  for (genvar g = 0; g < LANES; g++) begin : g_lane_io
    assign in_lane[g]                  = $signed(bus.in_u[g*WIDTH +: WIDTH]);
    assign bus.out_x[g*WIDTH +: WIDTH] = s2_x_q[g];
  end

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      clamp_u[i]    = in_lane[i];
      clamp_flag[i] = 1'b0;
      if (in_lane[i] < LO) begin
        clamp_u[i]    = LO;
        clamp_flag[i] = 1'b1;
      end else if (in_lane[i] > HI) begin
        clamp_u[i]    = HI;
        clamp_flag[i] = 1'b1;
      end
    end
  end

  // Clamped values lie in [EPS, ONE-EPS], so ONE-u stays positive at WIDTH bits.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (s1_u_q[i] < HALF) begin
        fold_x[i]   = uword_t'(s1_u_q[i]);
        fold_neg[i] = 1'b1;
      end else begin
        fold_x[i]   = uword_t'(ONE - s1_u_q[i]);
        fold_neg[i] = 1'b0;
      end
      fold_tail[i] = fold_x[i] < TAIL;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_u_d       = s1_u_q;
    s1_clamped_d = s1_clamped_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_x_d       = s2_x_q;
    s2_negate_d  = s2_negate_q;
    s2_tail_d    = s2_tail_q;
    s2_clamped_d = s2_clamped_q;
    s2_tag_d     = s2_tag_q;
    beat_count_d = beat_count_q;

    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_u_d       = clamp_u;
        s1_clamped_d = clamp_flag;
        s1_tag_d     = bus.in_tag;
      end
    end

    // Payload only changes when a real beat moves in, so a stalled output never glitches.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_x_d       = fold_x;
        s2_negate_d  = fold_neg;
        s2_tail_d    = fold_tail;
        s2_clamped_d = s1_clamped_q;
        s2_tag_d     = s1_tag_q;
      end
    end

    if (in_fire && (beat_count_q != '1)) begin
      beat_count_d = beat_count_q + 32'd1;
    end
  end

  // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are cleared as well, because the outputs must read zero after reset.
      s1_valid_q   <= 1'b0;
      s1_clamped_q <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_negate_q  <= '0;
      s2_tail_q    <= '0;
      s2_clamped_q <= '0;
      s2_tag_q     <= '0;
      beat_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_u_q[i] <= '0;
        s2_x_q[i] <= '0;
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_u_q       <= s1_u_d;
      s1_clamped_q <= s1_clamped_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_x_q       <= s2_x_d;
      s2_negate_q  <= s2_negate_d;
      s2_tail_q    <= s2_tail_d;
      s2_clamped_q <= s2_clamped_d;
      s2_tag_q     <= s2_tag_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_negate  = s2_negate_q;
  assign bus.out_tail    = s2_tail_q;
  assign bus.out_clamped = s2_clamped_q;
  assign bus.out_tag     = s2_tag_q;
  assign beat_count      = beat_count_q;

endmodule
